// File: rtl/l2_in_arbiter.sv
// L2 input arbiter: strict priority rsp > fwd > flush > cpu into a one-entry grant slot; optional CPU anti-starvation under L2_ARB_ANTISTARVE_EN.
// Accept-to-grant_valid is 1 cycle; *_ready are combinational and drop while the slot is held and grant_ready is low.
module l2_in_arbiter #(
  parameter int STARVE_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rsp_in_valid,
  input  logic       fwd_in_valid,
  input  logic       flush_valid,
  input  logic       cpu_req_valid,
  input  logic       fwd_stall,
  input  logic       cpu_req_conflict,
  input  logic       mshr_full,
  input  logic       flush_done,
  output logic       rsp_in_ready,
  output logic       fwd_in_ready,
  output logic       flush_ready,
  output logic       cpu_req_ready,
  output logic       grant_valid,
  output logic [1:0] grant_src,
  input  logic       grant_ready,
  output logic       flush_active
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  logic [0:0] state;
  logic       slot_free;
  logic       rsp_el, fwd_el, flush_el, cpu_el;
  logic       boost;
  logic       rsp_win, fwd_win, flush_win, cpu_win, accept;
  logic [1:0] win_src;

  assign flush_active = (state == ST_FLUSH);
  assign slot_free    = !grant_valid || grant_ready;

  assign rsp_el   = rsp_in_valid;
  assign fwd_el   = fwd_in_valid && !fwd_stall;
  assign flush_el = flush_valid && !mshr_full && !flush_active;
  assign cpu_el   = cpu_req_valid && !cpu_req_conflict && !mshr_full && !flush_active;

  // A boosted CPU request jumps fwd and flush but responses always drain first.
  assign rsp_win   = rst && slot_free && rsp_el;
  assign fwd_win   = rst && slot_free && fwd_el && !rsp_el && !(boost && cpu_el);
  assign flush_win = rst && slot_free && flush_el && !rsp_el && !fwd_el && !(boost && cpu_el);
  assign cpu_win   = rst && slot_free && cpu_el && !rsp_el && (boost || (!fwd_el && !flush_el));
  assign accept    = rsp_win || fwd_win || flush_win || cpu_win;

  assign rsp_in_ready  = rsp_win;
  assign fwd_in_ready  = fwd_win;
  assign flush_ready   = flush_win;
  assign cpu_req_ready = cpu_win;

  always_comb begin
    win_src = 2'd0;
    if (fwd_win)   win_src = 2'd1;
    if (flush_win) win_src = 2'd2;
    if (cpu_win)   win_src = 2'd3;
  end

`ifdef L2_ARB_ANTISTARVE_EN
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0] starve_cnt;

  assign boost = (starve_cnt == CW'(STARVE_MAX));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (!cpu_el || cpu_win) begin
      starve_cnt <= '0;
    end else if (slot_free && (starve_cnt != CW'(STARVE_MAX))) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  assign boost = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_valid <= 1'b0;
      grant_src   <= 2'd0;
    end else if (accept) begin
      grant_valid <= 1'b1;
      grant_src   <= win_src;
    end else if (grant_ready) begin
      grant_valid <= 1'b0;
    end
  end

  // flush_done seen while idle falls through the default hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (flush_win) state <= ST_FLUSH;
        ST_FLUSH: if (flush_done) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/l2_in_arbiter.md
# l2_in_arbiter

Input arbiter for the L2 cache controller. It decides each cycle which incoming channel the L2 core services next: LLC/L2 responses, forwarded requests, flush requests, or CPU requests. It applies strict priority plus blocking rules (MSHR full, set conflict, forward stall, flush in progress). The chosen source is registered in a one-entry grant slot that the L2 core drains with a valid/ready handshake. Payloads stay in the channel buffers; this block only sequences who is accepted.

## Interface

- STARVE_MAX, 15: cycles an eligible CPU request may lose before it is boosted.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- rsp_in_valid  in  1  response channel has a message.
- fwd_in_valid  in  1  forward channel has a message.
- flush_valid  in  1  flush request pending.
- cpu_req_valid  in  1  CPU request pending.
- fwd_stall  in  1  forwarded request targets a busy MSHR set; fwd ineligible.
- cpu_req_conflict  in  1  CPU request set matches a pending MSHR entry; cpu ineligible.
- mshr_full  in  1  no free MSHR; cpu and flush ineligible.
- flush_done  in  1  single-cycle pulse from core: flush sweep finished.
- rsp_in_ready, fwd_in_ready, flush_ready, cpu_req_ready  out  1 each  accept strobe; at most one high per cycle.
- grant_valid  out  1  grant slot occupied.
- grant_src  out  2  0=rsp, 1=fwd, 2=flush, 3=cpu.
- grant_ready  in  1  core consumes grant slot.
- flush_active  out  1  flush in progress.

## Operation

- Slot free = !grant_valid || grant_ready. Accept only when slot free.
- Eligibility:
  - rsp: valid.
  - fwd: valid && !fwd_stall.
  - flush: valid && !mshr_full && !flush_active.
  - cpu: valid && !cpu_req_conflict && !mshr_full && !flush_active.
- Priority: rsp > fwd > flush > cpu. Exactly the winner's *_ready is asserted, combinationally, in the same cycle as its valid. Handshake completes on valid && ready.
- On accept, grant_src is loaded with the winner and grant_valid is set.
- On drain without a new accept, grant_valid is cleared and grant_src is held.
- FSM for flush_active (IDLE/FLUSH):
  - IDLE -> FLUSH on a flush accept.
  - FLUSH -> IDLE on flush_done.
  - flush_done in IDLE is ignored.
  - rsp and fwd continue to be granted during FLUSH.
- A grant_ready with grant_valid low is ignored.
- An input that drops valid before acceptance loses its turn. There is no stored request.
- Reset (rst low, any time, including mid-handshake or mid-flush):
  - grant_valid=0, grant_src=0, flush_active=0, starve counter=0.
  - All *_ready forced 0 while rst is low.

## Timing

- Decision to grant_valid: 1 cycle. A request accepted in cycle N appears on grant_valid/grant_src in N+1.
- Throughput: 1 grant/cycle when the core holds grant_ready high; back-to-back accepts allowed in the drain cycle.
- flush_active rises the cycle after the flush accept and falls the cycle after flush_done.
- A cpu or flush request arriving in the same cycle as flush_done is not eligible that cycle. It is eligible the next cycle.
- *_ready paths are combinational from valids, blockers, grant_valid, grant_ready and registered state only. No path from a *_ready output back to an input.

## Configuration

- L2_ARB_ANTISTARVE_EN defined:
  - Counter of width $clog2(STARVE_MAX+1).
  - Increments each cycle cpu is eligible, the slot is free and cpu is not granted. Saturates at STARVE_MAX.
  - Clears on cpu accept or when cpu is not eligible.
  - At STARVE_MAX, cpu outranks fwd and flush but never rsp, since responses must always drain.
- Undefined: strict priority only; the counter logic is absent.

## Test plan

- Reset: rst low with all valids high -> all *_ready=0, grant_valid=0, grant_src=0, flush_active=0; after release, first grant_src=0.
- Priority: rsp, fwd and cpu valid in cycle N, grant_ready=1 -> rsp_in_ready at N, fwd_in_ready at N+1, cpu_req_ready at N+2; grant_src sequence 0,1,3 on N+1..N+3.
- Blocking: fwd_stall=1, mshr_full=1, fwd/flush/cpu valid -> no ready. Drop mshr_full -> flush_ready. Then flush_active=1 and cpu blocked until flush_done. cpu_req_ready comes 1 cycle after flush_done.
- Backpressure: grant_ready=0 for 5 cycles with rsp valid -> one accept, then rsp_in_ready=0 and grant_valid held with grant_src=0. grant_ready=1 -> accept in the same cycle.
- Anti-starvation (macro on, STARVE_MAX=15): fwd and cpu valid continuously -> fwd wins 15 cycles, cpu accepted on the 16th, counter returns to 0. Same stimulus plus rsp valid -> cpu never beats rsp.
- Mid-flush reset: assert rst while flush_active=1 -> flush_active=0 immediately; a flush request is accepted again after release.
